// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the iREN/ihit handshake and holds the fetched word.
// Optional build macro FETCH_PERFCNT_EN adds the fetch_count/stall_count performance counters.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] npc,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
`ifdef FETCH_PERFCNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_FETCH  = 2'd1,
    S_VALID  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t state;

  // Instruction targets are word aligned; the low two address bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    align_pc = target & 32'hFFFF_FFFC;
  endfunction

  assign iaddr = pc;
  assign npc   = pc + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_RESET;
      pc          <= PC_RESET;
      instr       <= 32'h0;
      iREN        <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state <= S_FETCH;
          iREN  <= 1'b1;
        end
        S_FETCH: begin
          if (ihit) begin
            instr       <= iload;
            state       <= S_VALID;
            iREN        <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (advance) begin
            instr_valid <= 1'b0;
            // Halt takes priority over any redirect on the same retiring instruction.
            if (halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              pc    <= redirect ? align_pc(redirect_pc) : npc;
              state <= S_FETCH;
              iREN  <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

`ifdef FETCH_PERFCNT_EN
  // Counters only move in FETCH, so they freeze automatically once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else if (state == S_FETCH) begin
      if (ihit) fetch_count <= fetch_count + 32'd1;
      else      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_unit;

  logic        CLK;
  logic        nRST, nRST2;
  logic        ihit, advance, redirect, halt;
  logic [31:0] iload, redirect_pc;

  logic        iREN, instr_valid, halted;
  logic [31:0] iaddr, instr, pc, npc;
  logic        iren2, valid2, halted2;
  logic [31:0] iaddr2, instr2, pc2, npc2;
`ifdef FETCH_PERFCNT_EN
  logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
  localparam int VW = 3 + 4 * 32 + 64;
`else
  localparam int VW = 3 + 4 * 32;
`endif

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .npc(npc), .advance(advance),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
`ifdef FETCH_PERFCNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) dut_wrap (
    .CLK(CLK), .nRST(nRST2), .iREN(iren2), .iaddr(iaddr2), .ihit(ihit), .iload(iload),
    .instr(instr2), .instr_valid(valid2), .pc(pc2), .npc(npc2), .advance(advance),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .halted(halted2)
`ifdef FETCH_PERFCNT_EN
    , .fetch_count(fetch_count2), .stall_count(stall_count2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference model: what the fetch stage is doing, in plain terms.
  localparam int P_IDLE = 0, P_FETCH = 1, P_HOLD = 2, P_STOP = 3;
  int          m_phase;
  logic [31:0] m_pc, m_instr, m_fetches, m_stalls;

  logic [VW-1:0] act_vec;
`ifdef FETCH_PERFCNT_EN
  assign act_vec = {iREN, instr_valid, halted, iaddr, instr, pc, npc, fetch_count, stall_count};
`else
  assign act_vec = {iREN, instr_valid, halted, iaddr, instr, pc, npc};
`endif

  function automatic logic [VW-1:0] exp_vec();
    logic [31:0] nxt;
    nxt = m_pc + 32'd4;
`ifdef FETCH_PERFCNT_EN
    exp_vec = {m_phase == P_FETCH, m_phase == P_HOLD, m_phase == P_STOP, m_pc, m_instr, m_pc, nxt,
               m_fetches, m_stalls};
`else
    exp_vec = {m_phase == P_FETCH, m_phase == P_HOLD, m_phase == P_STOP, m_pc, m_instr, m_pc, nxt};
`endif
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_pc = 32'h0; m_instr = 32'h0; m_fetches = 32'h0; m_stalls = 32'h0;
  endtask

  task automatic model_edge();
    if (m_phase == P_IDLE) m_phase = P_FETCH;
    else if (m_phase == P_FETCH) begin
      if (ihit) begin m_instr = iload; m_phase = P_HOLD; m_fetches = m_fetches + 1; end
      else m_stalls = m_stalls + 1;
    end else if (m_phase == P_HOLD && advance) begin
      if (halt) m_phase = P_STOP;
      else begin
        m_pc = redirect ? {redirect_pc[31:2], 2'b00} : m_pc + 32'd4;
        m_phase = P_FETCH;
      end
    end
  endtask

  task automatic drive(input logic ih, input logic [31:0] ld, input logic adv,
                       input logic rd, input logic [31:0] rpc, input logic hl);
    ihit = ih; iload = ld; advance = adv; redirect = rd; redirect_pc = rpc; halt = hl;
  endtask

  task automatic run_cycle();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    model_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    nRST = 1'b1; nRST2 = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0);
    #2;
    nRST = 1'b0; nRST2 = 1'b0;
    #1;
    checks++;
    if ({iREN, instr_valid, halted, pc, instr, npc} !== {3'b000, 32'h0, 32'h0, 32'h4}) begin
      failures++;
      $display("FAIL reset_state act=%b/%b/%b pc=%h instr=%h npc=%h exp iREN=0 valid=0 halted=0 pc=0 instr=0 npc=4",
               iREN, instr_valid, halted, pc, instr, npc);
    end
    do_reset();
  endtask

  task automatic test_sequential();
    logic        exp_valid [5];
    logic [31:0] exp_addr;
    exp_valid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_addr = 32'h0;
    do_reset();
    drive(1'b1, 32'h1111_0000, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        checks++;
        if (instr_valid !== exp_valid[i]) begin
          failures++;
          $display("FAIL seq_valid[%0d] act=%b exp=%b", i, instr_valid, exp_valid[i]);
        end
      end
      if (iREN === 1'b1) begin
        checks++;
        if (iaddr !== exp_addr) begin
          failures++;
          $display("FAIL seq_iaddr act=%h exp=%h", iaddr, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
      end
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL seq_model[%0d] act=%h exp=%h", i, act_vec, exp_vec());
      end
      iload = 32'h1111_0000 + i;
      run_cycle();
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (iREN !== 1'b1 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_iren[%0d] act=%b/%b exp=1/0", k, iREN, instr_valid);
      end
      ihit = (k == 3);
      iload = (k == 3) ? 32'h2401_0005 : 32'hFFFF_FFFF;
      run_cycle();
    end
    checks++;
    if ({iREN, instr_valid, instr} !== {2'b01, 32'h2401_0005}) begin
      failures++;
      $display("FAIL stall_result act iREN=%b valid=%b instr=%h exp 0/1/24010005", iREN, instr_valid, instr);
    end
`ifdef FETCH_PERFCNT_EN
    checks++;
    if (stall_count !== 32'd3 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL stall_counters act stall=%0d fetch=%0d exp 3/1", stall_count, fetch_count);
    end
`endif
    checks++;
    if (act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL stall_model act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_redirect();
    int n;
    do_reset();
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (!(instr_valid === 1'b1 && pc === 32'h10) && n < 20) begin
      run_cycle();
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL redir_reach timeout act pc=%h valid=%b exp pc=00000010 valid=1", pc, instr_valid);
    end
    drive(1'b1, 32'h0, 1'b0, 1'b1, 32'h43, 1'b0);
    for (int k = 0; k < 2; k++) begin
      run_cycle();
      checks++;
      if ({pc, iREN, instr_valid} !== {32'h10, 2'b01}) begin
        failures++;
        $display("FAIL redir_noadv act pc=%h iREN=%b valid=%b exp 00000010/0/1", pc, iREN, instr_valid);
      end
    end
    advance = 1'b1;
    run_cycle();
    checks++;
    if ({iaddr, npc, iREN} !== {32'h40, 32'h44, 1'b1}) begin
      failures++;
      $display("FAIL redir_target act iaddr=%h npc=%h iREN=%b exp 00000040/00000044/1", iaddr, npc, iREN);
    end
    checks++;
    if (act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL redir_model act=%h exp=%h", act_vec, exp_vec());
    end
  endtask

  task automatic test_halt();
    logic [31:0] held_instr;
    do_reset();
    drive(1'b1, 32'hABCD_1234, 1'b0, 1'b0, 32'h0, 1'b0);
    run_cycle();
    run_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1);
    run_cycle();
    held_instr = 32'hABCD_1234;
    checks++;
    if ({halted, iREN, instr_valid, pc} !== {3'b100, 32'h0}) begin
      failures++;
      $display("FAIL halt_enter act halted=%b iREN=%b valid=%b pc=%h exp 1/0/0/00000000", halted, iREN, instr_valid, pc);
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
      run_cycle();
      checks++;
      if ({halted, iREN, instr_valid, pc, instr} !== {3'b100, 32'h0, held_instr} || act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL halt_hold[%0d] act halted=%b iREN=%b pc=%h instr=%h exp 1/0/00000000/%h", k, halted, iREN, pc, instr, held_instr);
      end
    end
  endtask

  task automatic test_pc_wrap();
    @(negedge CLK);
    drive(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 1'b0);
    nRST2 = 1'b1;
    checks++;
    if ({iren2, iaddr2, npc2} !== {1'b0, 32'hFFFF_FFFC, 32'h0}) begin
      failures++;
      $display("FAIL wrap_reset act iREN=%b iaddr=%h npc=%h exp 0/fffffffc/00000000", iren2, iaddr2, npc2);
    end
    @(negedge CLK);
    checks++;
    if ({iren2, iaddr2, npc2} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      failures++;
      $display("FAIL wrap_fetch act iREN=%b iaddr=%h npc=%h exp 1/fffffffc/00000000", iren2, iaddr2, npc2);
    end
    @(negedge CLK);
    checks++;
    if ({valid2, instr2} !== {1'b1, 32'h5555_AAAA}) begin
      failures++;
      $display("FAIL wrap_valid act valid=%b instr=%h exp 1/5555aaaa", valid2, instr2);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge CLK);
    checks++;
    if ({iren2, iaddr2, npc2} !== {1'b1, 32'h0, 32'h4}) begin
      failures++;
      $display("FAIL wrap_next act iREN=%b iaddr=%h npc=%h exp 1/00000000/00000004", iren2, iaddr2, npc2);
    end
    nRST2 = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    drive(1'b1, 32'h7777_0001, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) run_cycle();
    ihit = 1'b0;
    run_cycle();
    run_cycle();
    checks++;
    if ({iREN, pc} !== {1'b1, 32'h4}) begin
      failures++;
      $display("FAIL midfetch_setup act iREN=%b pc=%h exp 1/00000004", iREN, pc);
    end
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec !== exp_vec() || iREN !== 1'b0 || pc !== 32'h0) begin
      failures++;
      $display("FAIL midfetch_async act=%h exp=%h", act_vec, exp_vec());
    end
    @(negedge CLK);
    nRST = 1'b1;
    ihit = 1'b1;
    checks++;
    if (iREN !== 1'b0) begin
      failures++;
      $display("FAIL midfetch_idle act iREN=%b exp 0", iREN);
    end
    run_cycle();
    checks++;
    if ({iREN, iaddr} !== {1'b1, 32'h0} || act_vec !== exp_vec()) begin
      failures++;
      $display("FAIL midfetch_restart act iREN=%b iaddr=%h exp 1/00000000", iREN, iaddr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      checks++;
      if (act_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d] act=%h exp=%h", i, act_vec, exp_vec());
      end
      if (m_phase == P_STOP && $urandom_range(0, 3) == 0) do_reset();
      drive($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 19) == 0);
      run_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_pc_wrap();
    test_reset_midfetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
